// File: rtl/log_pkg.sv
// rtl/log_pkg.sv - shared types and sizing for the log sink.
package log_pkg;

   localparam int FIFO_DEPTH = 8;
   localparam int SEQ_W      = 6;
   localparam int PTR_W      = 3;
   localparam int LVL_W      = 4;

   typedef enum logic [1:0] {
      LOG_INFO    = 2'd0,
      LOG_WARNING = 2'd1,
      LOG_ERROR   = 2'd2,
      LOG_UNKNOWN = 2'd3
   } log_type_e;

   typedef struct packed {
      log_type_e        typ;
      logic [SEQ_W-1:0] seq;
      logic [7:0]       data;
   } log_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } out_state_e;

   function automatic logic [7:0] hdr_byte(input log_entry_t e);
      return {e.typ, e.seq};
   endfunction

endpackage

// File: rtl/log_sink_fifo.sv
// rtl/log_sink_fifo.sv - 8-deep entry FIFO with head and post-pop head lookahead.
module log_sink_fifo
   import log_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  log_entry_t       wr_data_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [LVL_W-1:0] level_o,
   output log_entry_t       head_o,
   output log_entry_t       next_head_o
);

   log_entry_t       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, rd_nxt;
   logic [LVL_W-1:0] level_q;
   logic             wr_en, rd_en;

   assign full_o  = (level_q == LVL_W'(FIFO_DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign wr_en   = push_i && (!full_o || pop_i);
   assign rd_en   = pop_i && !empty_o;
   assign rd_nxt  = rd_ptr_q + 1'b1;
   assign head_o  = mem_q[rd_ptr_q];
   // Head after a pop; with one entry left it is whatever is pushed this cycle.
   assign next_head_o = (level_q > LVL_W'(1)) ? mem_q[rd_nxt] : wr_data_i;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_nxt;
         case ({wr_en, rd_en})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/log_sink.sv
// rtl/log_sink.sv - log entry buffer serializing each entry as header byte then data byte.
module log_sink
   import log_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        log_entry_valid,
   input  logic [1:0]  log_entry_type,
   input  logic [7:0]  log_entry_data,
   output logic        out_valid,
   output logic [7:0]  out_byte,
   input  logic        out_ready,
   input  logic        clear_stats,
   output logic [3:0]  fifo_level,
   output logic [7:0]  drop_count,
   output logic [15:0] err_count
);

   out_state_e       state_q;
   logic             out_valid_q;
   logic [7:0]       out_byte_q;
   logic [SEQ_W-1:0] seq_q;
   logic [7:0]       drop_q, drop_d;
   logic [15:0]      err_q, err_d;

   logic             full, empty, pop, accept;
   logic [LVL_W-1:0] level;
   log_entry_t       wr_entry, head, next_head;

   assign pop      = (state_q == ST_DATA) && out_ready;
   assign accept   = log_entry_valid && (!full || pop);
   assign wr_entry = '{typ: log_type_e'(log_entry_type), seq: seq_q, data: log_entry_data};

   log_sink_fifo u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (accept),
      .pop_i       (pop),
      .wr_data_i   (wr_entry),
      .full_o      (full),
      .empty_o     (empty),
      .level_o     (level),
      .head_o      (head),
      .next_head_o (next_head)
   );

   always_comb begin
      drop_d = drop_q;
      err_d  = err_q;
      if (clear_stats) begin
         drop_d = '0;
         err_d  = '0;
      end else begin
         if (log_entry_valid && !accept && drop_q != 8'hFF) drop_d = drop_q + 1'b1;
         if (accept && log_entry_type == LOG_ERROR && err_q != 16'hFFFF) err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_q  <= '0;
         drop_q <= '0;
         err_q  <= '0;
      end else begin
         if (log_entry_valid) seq_q <= seq_q + 1'b1;
         drop_q <= drop_d;
         err_q  <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_byte_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (!empty) begin
               state_q     <= ST_HDR;
               out_valid_q <= 1'b1;
               out_byte_q  <= hdr_byte(head);
            end
            ST_HDR: if (out_ready) begin
               state_q    <= ST_DATA;
               out_byte_q <= head.data;
            end
            ST_DATA: if (out_ready) begin
               // Chain straight into the next header so streaming has no bubble.
               if (level > LVL_W'(1) || accept) begin
                  state_q    <= ST_HDR;
                  out_byte_q <= hdr_byte(next_head);
               end else begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid  = out_valid_q;
   assign out_byte   = out_byte_q;
   assign fifo_level = level;
   assign drop_count = drop_q;
   assign err_count  = err_q;

endmodule

// File: tb/tb_log_sink.sv
// tb/tb_log_sink.sv - directed self-checking bench for log_sink.
module tb_log_sink;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        log_entry_valid;
   logic [1:0]  log_entry_type;
   logic [7:0]  log_entry_data;
   logic        out_valid;
   logic [7:0]  out_byte;
   logic        out_ready;
   logic        clear_stats;
   logic [3:0]  fifo_level;
   logic [7:0]  drop_count;
   logic [15:0] err_count;

   int n_cmp = 0;
   int n_bad = 0;

   log_sink dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .log_entry_valid (log_entry_valid),
      .log_entry_type  (log_entry_type),
      .log_entry_data  (log_entry_data),
      .out_valid       (out_valid),
      .out_byte        (out_byte),
      .out_ready       (out_ready),
      .clear_stats     (clear_stats),
      .fifo_level      (fifo_level),
      .drop_count      (drop_count),
      .err_count       (err_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic put(input logic [1:0] t, input logic [7:0] d);
      log_entry_valid = 1'b1;
      log_entry_type  = t;
      log_entry_data  = d;
   endtask

   initial begin
      rst_n           = 1'b0;
      log_entry_valid = 1'b0;
      log_entry_type  = 2'd0;
      log_entry_data  = 8'd0;
      out_ready       = 1'b0;
      clear_stats     = 1'b0;
      #3;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_byte",  32'(out_byte),  32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_drop",  32'(drop_count), 32'd0);
      chk("rst_err",   32'(err_count),  32'd0);
      tick();
      rst_n = 1'b1;

      // single ERROR entry, first edge after reset release
      out_ready = 1'b1;
      put(2'd2, 8'hC3);
      tick();
      log_entry_valid = 1'b0;
      chk("single_level1", 32'(fifo_level), 32'd1);
      chk("single_idle",   32'(out_valid),  32'd0);
      chk("single_err",    32'(err_count),  32'd1);
      tick();
      chk("single_hdr_v",  32'(out_valid), 32'd1);
      chk("single_hdr",    32'(out_byte),  32'h80);
      tick();
      chk("single_data",   32'(out_byte),  32'hC3);
      tick();
      chk("single_done_v", 32'(out_valid),  32'd0);
      chk("single_done_l", 32'(fifo_level), 32'd0);

      // overflow: 10 WARNING entries into a stalled sink
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         put(2'd1, 8'(i));
         tick();
      end
      log_entry_valid = 1'b0;
      chk("ovf_level", 32'(fifo_level), 32'd8);
      chk("ovf_drop",  32'(drop_count), 32'd2);
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("ovf_v%0d", k), 32'(out_valid), 32'd1);
         chk($sformatf("ovf_b%0d", k), 32'(out_byte),
             (k % 2 == 0) ? 32'(8'h40 | 8'(k / 2)) : 32'(k / 2));
         tick();
      end
      chk("ovf_end_v", 32'(out_valid),  32'd0);
      chk("ovf_end_l", 32'(fifo_level), 32'd0);
      put(2'd1, 8'hAA);
      tick();
      log_entry_valid = 1'b0;
      tick();
      chk("ovf_seq10", 32'(out_byte), 32'h4A);
      tick();
      chk("ovf_seq10_d", 32'(out_byte), 32'hAA);
      tick();
      chk("ovf_seq10_e", 32'(out_valid), 32'd0);

      // backpressure stall in HDR and DATA (seq 11)
      out_ready = 1'b0;
      put(2'd0, 8'h5A);
      tick();
      log_entry_valid = 1'b0;
      tick();
      chk("bp_hdr", 32'(out_byte), 32'h0B);
      tick();
      chk("bp_hdr_hold", 32'(out_byte), 32'h0B);
      chk("bp_hdr_v",    32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick();
      chk("bp_data", 32'(out_byte), 32'h5A);
      out_ready = 1'b0;
      tick();
      chk("bp_hold1", 32'(out_byte), 32'h5A);
      tick();
      chk("bp_hold2", 32'(out_byte), 32'h5A);
      chk("bp_hold_l", 32'(fifo_level), 32'd1);
      out_ready = 1'b1;
      tick();
      chk("bp_done_v", 32'(out_valid),  32'd0);
      chk("bp_done_l", 32'(fifo_level), 32'd0);

      // full plus same-cycle pop (seq 12..19, then 20)
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         put(2'd0, 8'(8'h10 + i));
         tick();
      end
      log_entry_valid = 1'b0;
      chk("fp_level", 32'(fifo_level), 32'd8);
      chk("fp_hdr",   32'(out_byte),   32'h0C);
      out_ready = 1'b1;
      tick();
      chk("fp_data", 32'(out_byte), 32'h10);
      put(2'd2, 8'h77);
      tick();
      log_entry_valid = 1'b0;
      chk("fp_level8", 32'(fifo_level), 32'd8);
      chk("fp_drop",   32'(drop_count), 32'd2);
      chk("fp_err",    32'(err_count),  32'd1);
      chk("fp_next",   32'(out_byte),   32'h0D);
      for (int i = 0; i < 14; i++) tick();
      chk("fp_last_hdr",  32'(out_byte), 32'h94);
      tick();
      chk("fp_last_data", 32'(out_byte), 32'h77);
      tick();
      chk("fp_drain_l", 32'(fifo_level), 32'd0);

      // saturation and clear
      out_ready = 1'b0;
      put(2'd0, 8'h00);
      for (int i = 0; i < 308; i++) tick();
      chk("sat_drop", 32'(drop_count), 32'd255);
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      chk("clr_drop", 32'(drop_count), 32'd0);
      chk("clr_err",  32'(err_count),  32'd0);
      tick();
      log_entry_valid = 1'b0;
      chk("post_clr_drop", 32'(drop_count), 32'd1);

      // reset mid-DATA with 3 UNKNOWN entries buffered
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         put(2'd3, 8'(i));
         tick();
      end
      log_entry_valid = 1'b0;
      chk("mr_level", 32'(fifo_level), 32'd3);
      chk("mr_hdr",   32'(out_byte),   32'hC0);
      chk("mr_err",   32'(err_count),  32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("mr_data", 32'(out_byte), 32'h01);
      rst_n = 1'b0;
      #1;
      chk("mr_rst_v", 32'(out_valid),  32'd0);
      chk("mr_rst_b", 32'(out_byte),   32'd0);
      chk("mr_rst_l", 32'(fifo_level), 32'd0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      put(2'd1, 8'h33);
      tick();
      log_entry_valid = 1'b0;
      tick();
      chk("mr_seq0_v", 32'(out_valid), 32'd1);
      chk("mr_seq0",   32'(out_byte),  32'h40);
      tick();
      chk("mr_seq0_d", 32'(out_byte), 32'h33);
      tick();
      chk("mr_end_l", 32'(fifo_level), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/log_sink.md
LOG_SINK -- requirements
Module: log_sink

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  async active-low reset.
REQ-004 log_entry_valid  input  1  one-cycle log entry strobe; no backpressure.
REQ-005 log_entry_type  input  2  0=INFO, 1=WARNING, 2=ERROR, 3=UNKNOWN.
REQ-006 log_entry_data  input  8  entry payload.
REQ-007 out_valid  output  1  byte available on out_byte.
REQ-008 out_byte  output  8  serialized byte stream: header then data per entry.
REQ-009 out_ready  input  1  downstream accepts byte when out_valid && out_ready at rising edge.
REQ-010 clear_stats  input  1  synchronous clear of drop_count and err_count.
REQ-011 fifo_level  output  4  entries currently buffered, 0..8.
REQ-012 drop_count  output  8  entries lost to overflow, saturating.
REQ-013 err_count  output  16  accepted ERROR entries, saturating.

Function
REQ-014 The block SHALL buffer entries in an 8-deep FIFO; each slot holds {type[1:0], seq[5:0], data[7:0]}.
REQ-015 seq SHALL be a 6-bit counter incremented on every sampled log_entry_valid, accepted or dropped; wraps 63->0, so drops appear as seq gaps.
REQ-016 An entry SHALL be accepted when fifo_level<8, or when fifo_level==8 and a pop occurs in the same cycle; otherwise it is dropped.
REQ-017 On drop, drop_count SHALL increment, saturating at 255.
REQ-018 On accepted entry with type 2, err_count SHALL increment, saturating at 65535.
REQ-019 clear_stats SHALL zero drop_count and err_count at the next edge; clear wins over a same-cycle increment.
REQ-020 Output FSM states SHALL be IDLE, HDR, DATA.
REQ-021 IDLE: out_valid=0; if fifo_level!=0, go to HDR.
REQ-022 HDR: out_valid=1, out_byte={type, seq} of FIFO head; on out_ready go to DATA.
REQ-023 DATA: out_valid=1, out_byte=head data; on out_ready pop head; next state HDR if entries remain after the pop (including a same-cycle push), else IDLE.
REQ-024 While out_valid=1 and out_ready=0, out_valid and out_byte SHALL remain stable.
REQ-025 Latency: an entry sampled into an empty, idle FIFO at edge E SHALL produce out_valid=1 with its header after edge E+1.
REQ-026 Back-to-back streaming SHALL sustain one byte per cycle with out_ready held high, with no IDLE bubble between entries.
REQ-027 Type 3 entries SHALL be buffered and streamed unchanged, counted in neither err_count nor any filter.
REQ-028 fifo_level SHALL be registered and reflect push/pop at each edge; simultaneous push and pop leave it unchanged.

Reset
REQ-029 On rst_n low, immediately: out_valid=0, out_byte=0, fifo_level=0, drop_count=0, err_count=0, seq=0, FSM=IDLE; FIFO contents discarded.
REQ-030 Reset asserted mid-entry (HDR or DATA) SHALL abort the entry without popping it again after release; no partial entry is resent.
REQ-031 Entries presented on the first edge after rst_n rises SHALL be accepted normally.

Structure
REQ-032 A shared package log_pkg SHALL hold the log type enum (INFO, WARNING, ERROR, UNKNOWN), FIFO depth constant 8, and the seq width constant 6.
REQ-033 The FIFO SHALL be a sub-module log_sink_fifo (push, pop, full, empty, level, head data); FSM and counters stay in log_sink.

Verification
REQ-034 Single entry: type=2, data=0xC3, out_ready=1 -> bytes 0x80 then 0xC3; err_count=1, fifo_level returns 0.
REQ-035 Overflow: out_ready=0, 10 consecutive entries data 0x00..0x09 -> fifo_level=8, drop_count=2; then out_ready=1 -> 16 bytes, data 0x00..0x07, seq 0..7; next entry carries seq 10.
REQ-036 Backpressure: out_ready toggling 1,0,0,1 during HDR/DATA -> out_byte stable while stalled, no byte duplicated or lost.
REQ-037 Saturation/clear: 300 drops -> drop_count=255; clear_stats coincident with a drop -> drop_count=0.
REQ-038 Full plus pop: fifo_level=8, DATA accepted same cycle as new entry -> entry accepted, fifo_level stays 8, drop_count unchanged.
REQ-039 Reset mid-DATA: rst_n pulsed low with 3 entries buffered -> out_valid=0 immediately, fifo_level=0, next entry after release has seq 0.
